// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler: steps the PWM duty value through a programmable table, updating only at period boundaries.
// Build option PWM_SCHED_SOFTRAMP_EN: duty_out slews 1 LSB per period toward each new entry (and toward 0 on stop).
module pwm_duty_scheduler #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned HOLD_W = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [AW-1:0]     seq_last,
  input  logic [HOLD_W-1:0] hold_periods,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  input  logic              period_end,
  output logic [WIDTH-1:0]  duty_out,
  output logic              duty_load,
  output logic [AW-1:0]     step_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, ARM, HOLD, DONE, STOPPING} state_t;

  state_t              state, state_n;
  logic [WIDTH-1:0]    tbl [DEPTH];
  logic [HOLD_W-1:0]   cnt, cnt_n;
  logic [HOLD_W-1:0]   hold_r, hold_n;
  logic [AW-1:0]       last_r, last_n;
  logic                loop_r, loop_n;
  logic [WIDTH-1:0]    duty_n;
  logic [AW-1:0]       idx_n;
  logic                load_n;
  logic                do_load;
  logic [AW-1:0]       load_sel;

`ifdef PWM_SCHED_SOFTRAMP_EN
  logic [WIDTH-1:0]    tgt, tgt_n;

  function automatic logic [WIDTH-1:0] ramp_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] goal);
    if (cur < goal)      return cur + WIDTH'(1);
    else if (cur > goal) return cur - WIDTH'(1);
    else                 return cur;
  endfunction
`endif

  assign busy = (state == ARM) || (state == HOLD) || (state == STOPPING);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      duty_out  <= '0;
      duty_load <= 1'b0;
      step_idx  <= '0;
      cnt       <= '0;
      hold_r    <= HOLD_W'(1);
      last_r    <= '0;
      loop_r    <= 1'b0;
`ifdef PWM_SCHED_SOFTRAMP_EN
      tgt       <= '0;
`endif
    end else begin
      state     <= state_n;
      duty_out  <= duty_n;
      duty_load <= load_n;
      step_idx  <= idx_n;
      cnt       <= cnt_n;
      hold_r    <= hold_n;
      last_r    <= last_n;
      loop_r    <= loop_en ? loop_n : loop_n;
`ifdef PWM_SCHED_SOFTRAMP_EN
      tgt       <= tgt_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    duty_n   = duty_out;
    idx_n    = step_idx;
    cnt_n    = cnt;
    load_n   = 1'b0;
    hold_n   = hold_r;
    last_n   = last_r;
    loop_n   = loop_r;
    do_load  = 1'b0;
    load_sel = '0;
`ifdef PWM_SCHED_SOFTRAMP_EN
    tgt_n    = tgt;
`endif

    // With ena low nothing advances: start/stop/period_end are all dropped.
    if (ena) begin
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state_n = ARM;
            last_n  = seq_last;
            hold_n  = (hold_periods == '0) ? HOLD_W'(1) : hold_periods;
            loop_n  = loop_en;
          end
        end
        ARM: begin
          if (stop) begin
            state_n = STOPPING;
          end else if (period_end) begin
            do_load = 1'b1;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (stop) begin
            state_n = STOPPING;
          end else if (period_end) begin
`ifdef PWM_SCHED_SOFTRAMP_EN
            if (duty_out != tgt) begin
              duty_n = ramp_step(duty_out, tgt);
              load_n = 1'b1;
              if (duty_n == tgt) cnt_n = hold_r;
            end else
`endif
            if (cnt > HOLD_W'(1)) begin
              cnt_n = cnt - HOLD_W'(1);
            end else if (step_idx < last_r) begin
              do_load  = 1'b1;
              load_sel = step_idx + AW'(1);
            end else if (loop_r) begin
              do_load  = 1'b1;
            end else begin
              cnt_n   = '0;
              state_n = DONE;
            end
          end
        end
        DONE: begin
          if (stop) begin
            state_n = STOPPING;
          end else if (start) begin
            state_n = ARM;
            last_n  = seq_last;
            hold_n  = (hold_periods == '0) ? HOLD_W'(1) : hold_periods;
            loop_n  = loop_en;
          end
        end
        STOPPING: begin
          if (period_end) begin
            load_n = 1'b1;
`ifdef PWM_SCHED_SOFTRAMP_EN
            duty_n = ramp_step(duty_out, '0);
`else
            duty_n = '0;
`endif
            if (duty_n == '0) begin
              state_n = IDLE;
              idx_n   = '0;
              cnt_n   = '0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (do_load) begin
      idx_n  = load_sel;
      load_n = 1'b1;
`ifdef PWM_SCHED_SOFTRAMP_EN
      // Hold count only starts once the ramp has landed on the target.
      tgt_n  = tbl[load_sel];
      duty_n = ramp_step(duty_out, tbl[load_sel]);
      cnt_n  = (duty_n == tbl[load_sel]) ? hold_r : '0;
`else
      duty_n = tbl[load_sel];
      cnt_n  = hold_r;
`endif
    end
  end

endmodule
